fp_cvt_pipe: RTL

//  Pipelined, parametrised two's-complement to compact floating-point converter.

---
 rtl/fp_cvt_pipe_pkg.sv | 24 ++
 rtl/fp_lead_one_det.sv | 25 ++
 rtl/fp_cvt_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp_cvt_pipe_pkg.sv
// Shared defaults and elaboration helpers for the fp_cvt_pipe converter.
package fp_cvt_pipe_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_EXP_W  = 3;
  localparam int DEF_MANT_W = 4;

  // Largest encodable exponent for a given exponent width.
  function automatic int emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Width of a bit index into a W-bit vector.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Legal geometry: every shift the normaliser can need must be encodable in E.
  function automatic bit cfg_ok(input int data_w, input int exp_w, input int mant_w);
    return (data_w >= 6) && (data_w <= 32) && (exp_w >= 1) && (mant_w >= 1) &&
           (mant_w <= data_w - 1) && ((data_w - 1 - mant_w) <= emax(exp_w));
  endfunction

endpackage

// File: rtl/fp_lead_one_det.sv
// Combinational leading-one detector: index of the highest set bit plus an any-one flag.
module fp_lead_one_det
  import fp_cvt_pipe_pkg::*;
#(
  parameter int W = 11,
  localparam int IW = idx_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan upwards so the highest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_cvt_pipe.sv
// fp_cvt_pipe: three-stage streaming converter from two's complement to S/E/F
// compact float (value = F * 2^E, no hidden bit) with truncate or round-half-up.
module fp_cvt_pipe
  import fp_cvt_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [MANT_W-1:0] out_f,
  output logic              out_sat,
  output logic              out_inexact
);

  localparam int MW = DATA_W - 1;
  localparam int IW = idx_w(MW);
  localparam logic [EXP_W-1:0] EMAX = '1;

  if (!cfg_ok(DATA_W, EXP_W, MANT_W)) begin : g_bad_cfg
    $error("fp_cvt_pipe: illegal DATA_W/EXP_W/MANT_W combination");
  end

  logic adv;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_s_q, s1_s_d;
  logic [MW-1:0]     s1_m_q, s1_m_d;
  logic              s1_sat_q, s1_sat_d;
  logic              s1_rnd_q, s1_rnd_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_s_q, s2_s_d;
  logic [EXP_W-1:0]  s2_e_q, s2_e_d;
  logic [MANT_W-1:0] s2_f_q, s2_f_d;
  logic              s2_r_q, s2_r_d;
  logic              s2_inexact_q, s2_inexact_d;
  logic              s2_sat_q, s2_sat_d;
  logic              s2_rnd_q, s2_rnd_d;

  logic              out_valid_q, out_valid_d;
  logic              out_s_q, out_s_d;
  logic [EXP_W-1:0]  out_e_q, out_e_d;
  logic [MANT_W-1:0] out_f_q, out_f_d;
  logic              out_sat_q, out_sat_d;
  logic              out_inexact_q, out_inexact_d;

  logic [IW-1:0]     lod_idx;
  logic              lod_found;
  int                norm_sh;
  logic [MANT_W:0]   f_inc;

  // One shared enable: the whole pipe moves unless a held result is blocked.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // S1: sign and magnitude; the most-negative code clamps to the largest magnitude.
  always_comb begin
    s1_valid_d = in_valid;
    s1_s_d     = in_data[DATA_W-1];
    s1_rnd_d   = in_rnd;
    s1_sat_d   = 1'b0;
    if (in_data[DATA_W-1]) s1_m_d = MW'(DATA_W'(0) - in_data);
    else                   s1_m_d = in_data[MW-1:0];
    if (in_data == {1'b1, {MW{1'b0}}}) begin
      s1_m_d   = '1;
      s1_sat_d = 1'b1;
    end
  end

  // S1 stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_m_q     <= '0;
      s1_sat_q   <= 1'b0;
      s1_rnd_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d;
      s1_s_q     <= s1_s_d;
      s1_m_q     <= s1_m_d;
      s1_sat_q   <= s1_sat_d;
      s1_rnd_q   <= s1_rnd_d;
    end
  end

  fp_lead_one_det #(
    .W (MW)
  ) u_lod (
    .vec   (s1_m_q),
    .idx   (lod_idx),
    .found (lod_found)
  );

  // S2: normalise so the leading one lands in the mantissa MSB; the shift is E.
  always_comb begin
    norm_sh      = int'(lod_idx) - MANT_W + 1;
    s2_valid_d   = s1_valid_q;
    s2_s_d       = s1_s_q;
    s2_sat_d     = s1_sat_q;
    s2_rnd_d     = s1_rnd_q;
    s2_e_d       = '0;
    s2_f_d       = MANT_W'(s1_m_q);
    s2_r_d       = 1'b0;
    s2_inexact_d = 1'b0;
    if (lod_found && (norm_sh > 0)) begin
      s2_e_d       = EXP_W'(norm_sh);
      s2_f_d       = MANT_W'(s1_m_q >> norm_sh);
      s2_r_d       = 1'(s1_m_q >> (norm_sh - 1));
      s2_inexact_d = |(s1_m_q & ~({MW{1'b1}} << norm_sh));
    end
  end

  // S2 stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_s_q       <= 1'b0;
      s2_e_q       <= '0;
      s2_f_q       <= '0;
      s2_r_q       <= 1'b0;
      s2_inexact_q <= 1'b0;
      s2_sat_q     <= 1'b0;
      s2_rnd_q     <= 1'b0;
    end else if (adv) begin
      s2_valid_q   <= s2_valid_d;
      s2_s_q       <= s2_s_d;
      s2_e_q       <= s2_e_d;
      s2_f_q       <= s2_f_d;
      s2_r_q       <= s2_r_d;
      s2_inexact_q <= s2_inexact_d;
      s2_sat_q     <= s2_sat_d;
      s2_rnd_q     <= s2_rnd_d;
    end
  end

  // S3: round half-up; a mantissa carry renormalises, a carry past EMAX saturates.
  always_comb begin
    f_inc         = {1'b0, s2_f_q} + (MANT_W + 1)'(1);
    out_valid_d   = s2_valid_q;
    out_s_d       = s2_s_q;
    out_e_d       = s2_e_q;
    out_f_d       = s2_f_q;
    out_sat_d     = s2_sat_q;
    out_inexact_d = s2_inexact_q;
    if (s2_rnd_q && s2_r_q) begin
      if (!f_inc[MANT_W]) begin
        out_f_d = f_inc[MANT_W-1:0];
      end else if (s2_e_q == EMAX) begin
        out_f_d   = '1;
        out_sat_d = 1'b1;
      end else begin
        out_f_d           = '0;
        out_f_d[MANT_W-1] = 1'b1;
        out_e_d           = s2_e_q + EXP_W'(1);
      end
    end
  end

  // Output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_s_q       <= 1'b0;
      out_e_q       <= '0;
      out_f_q       <= '0;
      out_sat_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      out_valid_q   <= out_valid_d;
      out_s_q       <= out_s_d;
      out_e_q       <= out_e_d;
      out_f_q       <= out_f_d;
      out_sat_q     <= out_sat_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_s       = out_s_q;
  assign out_e       = out_e_q;
  assign out_f       = out_f_q;
  assign out_sat     = out_sat_q;
  assign out_inexact = out_inexact_q;

endmodule
